// File: rtl/rom_burst_arbiter.sv
// rom_burst_arbiter: two-requester round-robin arbiter that sequences bursts
// of 1-8 consecutive words from a shared 8x4 combinational ROM. The ROM
// address is driven straight from a register, the ROM word is captured every
// READ cycle, and each captured beat is tagged with its owner.
//
// Handshake: reqN is a level request, sampled only while idle. gntN pulses for
// one cycle when the burst is accepted; startN/lenN are captured on that same
// edge. The requester must keep reqN/startN/lenN stable until gntN and drop
// reqN before its burst ends, otherwise the held request is taken as a new
// burst when the block returns to idle. rd_valid qualifies rd_data, rd_id and
// rd_last; there is no back-pressure on the read beats.
module rom_burst_arbiter #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [ADDR_W-1:0] start0,
  input  logic [2:0]        len0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] start1,
  input  logic [2:0]        len1,
  output logic              gnt0,
  output logic              gnt1,
  output logic [ADDR_W-1:0] rom_adr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_id,
  output logic              rd_last,
  output logic              busy
);

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                owner_q, owner_d;
  logic                ptr_q, ptr_d;      // 0: requester 0 wins a tie
  logic                gnt0_q, gnt0_d;
  logic                gnt1_q, gnt1_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                rd_id_q, rd_id_d;
  logic                rd_last_q, rd_last_d;
  logic                winner;

  // busy is the FSM state itself: high exactly while a burst is in READ.
  assign busy     = (state_q == READ);
  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign rom_adr  = adr_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_id    = rd_id_q;
  assign rd_last  = rd_last_q;

  // Next-state logic: arbitration in IDLE, beat sequencing in READ.
  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    rd_id_d    = rd_id_q;
    rd_last_d  = rd_last_q;
    // A lone request wins outright; a tie goes to the pointer.
    winner     = (req0 && req1) ? ptr_q : req1;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = READ;
          adr_d   = winner ? start1 : start0;
          cnt_d   = winner ? len1 : len0;
          owner_d = winner;
          ptr_d   = ~winner;
          gnt0_d  = ~winner;
          gnt1_d  = winner;
        end
      end
      READ: begin
        rd_data_d  = rom_data;
        rd_valid_d = 1'b1;
        rd_id_d    = owner_q;
        rd_last_d  = (cnt_q == 3'd0);
        adr_d      = adr_q + ADDR_W'(1);
        cnt_d      = cnt_q - 3'd1;
        if (cnt_q == 3'd0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any burst in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      adr_q      <= '0;
      cnt_q      <= '0;
      owner_q    <= 1'b0;
      ptr_q      <= 1'b0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_id_q    <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      adr_q      <= adr_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_id_q    <= rd_id_d;
      rd_last_q  <= rd_last_d;
    end
  end

endmodule

// File: doc/rom_burst_arbiter.md
# rom_burst_arbiter

Two-requester round-robin arbiter and burst sequencer for the shared 8×4 combinational lookup ROM. Each requester asks for a burst of 1–8 consecutive ROM words from a start address, and the address wraps 7→0. The block drives the ROM address from a register, captures the ROM output each cycle, and returns tagged read beats. It is the only driver of the ROM address bus.

## Interface
- ADDR_W, 3, ROM address width; fixed to the ROM depth of 8.
- DATA_W, 4, ROM data width.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0  in  1  requester 0 burst request, level.
- start0  in  ADDR_W  requester 0 start address.
- len0  in  3  requester 0 burst length minus 1; burst is len0+1 beats.
- req1, start1, len1  in  1/ADDR_W/3  same fields for requester 1.
- gnt0  out  1  one-cycle pulse: requester 0 burst accepted.
- gnt1  out  1  one-cycle pulse: requester 1 burst accepted.
- rom_adr  out  ADDR_W  ROM address; a direct register output.
- rom_data  in  DATA_W  ROM data; combinational function of rom_adr.
- rd_data  out  DATA_W  captured ROM word.
- rd_valid  out  1  rd_data is a valid beat.
- rd_id  out  1  owner of the current beat: 0 or 1.
- rd_last  out  1  final beat of a burst; qualified by rd_valid.
- busy  out  1  high while a burst is in progress.

## Operation
- Two states: IDLE and READ. Reset enters IDLE.
- IDLE, no request: all outputs hold; rd_valid, gnt0 and gnt1 are 0.
- IDLE, at least one request: select a winner and, on the same edge:
  - load the address register from the winner's start field;
  - load the beat counter from the winner's len field;
  - load the owner register with the winner's ID;
  - set the winner's gnt, busy=1, and go to READ.
- Winner selection:
  - If only one req is high, that requester wins.
  - If both are high, the round-robin pointer decides.
  - After a grant, the pointer favors the other requester.
  - Reset sets the pointer to favor requester 0.
- READ, every edge:
  - rd_data ← rom_data; rd_valid ← 1; rd_id ← owner; rd_last ← (counter==0).
  - Address register increments modulo 8; counter decrements.
  - If counter==0: go to IDLE and clear busy.
- Input sampling:
  - req, start and len are sampled only in IDLE.
  - Changes to them during READ have no effect.
  - If a req is still high when the block returns to IDLE, it is taken as a new request.
- Requester contract: hold req, start and len stable until gnt, then drop req before the burst ends.
- rd_data holds its last value when rd_valid=0. rom_adr holds its last value in IDLE (the wrapped next address).
- Reset mid-burst: all registers return to reset values at once. The burst is discarded, and no further beats or grants appear.

## Timing
- Reset values: gnt0=0, gnt1=0, rd_valid=0, rd_data=0, rd_id=0, rd_last=0, busy=0, rom_adr=0. Pointer favors requester 0.
- Grant edge k: gnt and busy go high in cycle k+1, and rom_adr = start in cycle k+1.
- First beat: rd_valid is high in cycle k+2, one cycle after gnt.
- An N-beat burst produces rd_valid for N consecutive cycles, k+2 .. k+N+1. rd_last is high only in cycle k+N+1.
- busy is high in cycles k+1 .. k+N.
- Back-to-back bursts: the next grant is at edge k+N+1 at the earliest. This leaves exactly one rd_valid=0 bubble between bursts.
- Latency from req (block idle) to first beat: 2 cycles.

## Test plan
ROM contents for addresses 0..7 are 0, 13, 10, 8, 4, 11, 2, 1.
- **Single beat:** after reset, req0=1, start0=5, len0=0 → gnt0 pulses one cycle; next cycle rd_valid=1, rd_data=11, rd_id=0, rd_last=1; busy low afterwards.
- **Wrap:** req1=1, start1=6, len1=3 → four beats 2, 1, 0, 13 with rd_id=1, rd_last on the 4th, rom_adr ending at 2.
- **Full burst:** req0, start0=0, len0=7 → 8 consecutive beats 0, 13, 10, 8, 4, 11, 2, 1; busy high for 8 cycles.
- **Contention:** req0 and req1 both held high from reset, each with len=1 → grants in the order gnt0, gnt1, gnt0, gnt1. Each burst is 2 beats with one bubble cycle between bursts; rd_id alternates per burst.
- **Input changes ignored:** change start0 and len0 during an active burst → beats unaffected.
- **Reset mid-burst:** pull rst_n low after 2 beats of an 8-beat req1 burst → all outputs 0 immediately; no further beats. After release with both reqs high, gnt0 is granted first.
